// File: rtl/xnor_cmp_pkg.sv
// Shared constants and helpers for the xnor_cmp_pipe comparator.
// Parameter limits live here so every user checks against the same range.
package xnor_cmp_pkg;

   localparam int MIN_WIDTH  = 1;
   localparam int MAX_WIDTH  = 64;
   localparam int MIN_STAGES = 1;
   localparam int MAX_STAGES = 4;
   localparam int MIN_ERR_W  = 1;

   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

   // Sized for the widest legal operand; callers zero-extend and truncate.
   function automatic logic [6:0] popcount64(input logic [63:0] v);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) begin
         c = c + 7'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/xnor_cmp_stage.sv
// One pipeline slice of xnor_cmp_pipe: payload plus valid bit, loaded on enable.
// Payload resets to zero so the outputs read as zero while in reset.
module xnor_cmp_stage #(
   parameter int DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          en_i,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);

   logic          valid_q;
   logic [DW-1:0] data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (en_i) begin
         valid_q <= valid_i;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/xnor_cmp_pipe.sv
// Pipelined WIDTH-bit XNOR comparator with all-equal flag and match count.
// Optional saturating mismatch counter enabled by XNOR_CMP_ERR_CNT_EN.
module xnor_cmp_pipe
   import xnor_cmp_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int ERR_W  = 8
) (
   input  logic                       CLK,
   input  logic                       RSTn,
   input  logic [WIDTH-1:0]           A,
   input  logic [WIDTH-1:0]           B,
   input  logic                       Valid_in,
   output logic                       Ready_in,
   output logic [WIDTH-1:0]           Y,
   output logic                       Eq,
   output logic [cnt_w(WIDTH)-1:0]    Match_cnt,
   output logic                       Valid_out,
`ifdef XNOR_CMP_ERR_CNT_EN
   input  logic                       Err_clr,
   output logic [ERR_W-1:0]           Err_cnt,
`endif
   input  logic                       Ready_out
);

   localparam int CNT_W = cnt_w(WIDTH);
   localparam int DW    = WIDTH + CNT_W + 1;

   if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("xnor_cmp_pipe: WIDTH out of range");
   end
   if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
      $error("xnor_cmp_pipe: STAGES out of range");
   end
   if (ERR_W < MIN_ERR_W) begin : g_bad_err_w
      $error("xnor_cmp_pipe: ERR_W out of range");
   end

   logic          advance;
   logic [DW-1:0] st_d [STAGES];
   logic [DW-1:0] st_q [STAGES];
   logic          v_q  [STAGES];

   assign advance  = !Valid_out || Ready_out;
   assign Ready_in = advance;

   // Payload layout per stage: {y, cnt, eq}. Stage 0 carries only y; the
   // popcount is formed in stage 1 (or stage 0 when it is the only stage).
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic [WIDTH-1:0] y_in;
      logic [CNT_W-1:0] cnt_in;
      logic             eq_in;
      logic             v_in;

      if (i == 0) begin : g_first
         assign y_in = ~(A ^ B);
         assign v_in = Valid_in;
      end else begin : g_next
         assign y_in = st_q[i-1][DW-1 -: WIDTH];
         assign v_in = v_q[i-1];
      end

      if (i == 1 || STAGES == 1) begin : g_cnt
         assign cnt_in = CNT_W'(popcount64(64'(y_in)));
         assign eq_in  = (cnt_in == CNT_W'(WIDTH));
      end else if (i == 0) begin : g_nocnt
         assign cnt_in = '0;
         assign eq_in  = 1'b0;
      end else begin : g_pass
         assign cnt_in = st_q[i-1][CNT_W:1];
         assign eq_in  = st_q[i-1][0];
      end

      assign st_d[i] = {y_in, cnt_in, eq_in};

      xnor_cmp_stage #(.DW(DW)) u_stage (
         .clk_i   (CLK),
         .rst_ni  (RSTn),
         .en_i    (advance),
         .valid_i (v_in),
         .data_i  (st_d[i]),
         .valid_o (v_q[i]),
         .data_o  (st_q[i])
      );
   end

   assign Y         = st_q[STAGES-1][DW-1 -: WIDTH];
   assign Match_cnt = st_q[STAGES-1][CNT_W:1];
   assign Eq        = st_q[STAGES-1][0];
   assign Valid_out = v_q[STAGES-1];

`ifdef XNOR_CMP_ERR_CNT_EN
   logic [ERR_W-1:0] err_q;
   logic [ERR_W-1:0] err_d;

   // Clear wins over a same-cycle increment; the count saturates at all-ones.
   always_comb begin
      err_d = err_q;
      if (Err_clr) begin
         err_d = '0;
      end else if (Valid_out && Ready_out && !Eq && (err_q != '1)) begin
         err_d = err_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end

   assign Err_cnt = err_q;
`endif

endmodule

// File: tb/tb_xnor_cmp_pipe.sv
// Self-checking bench for xnor_cmp_pipe (WIDTH=8, STAGES=2, ERR_W=2).
// Mismatch-counter checks are active when XNOR_CMP_ERR_CNT_EN is defined.
module tb_xnor_cmp_pipe;

   localparam int WIDTH  = 8;
   localparam int STAGES = 2;
   localparam int ERR_W  = 2;

   logic       CLK;
   logic       RSTn;
   logic [7:0] A, B;
   logic       Valid_in, Ready_in;
   logic [7:0] Y;
   logic       Eq;
   logic [3:0] Match_cnt;
   logic       Valid_out, Ready_out;
`ifdef XNOR_CMP_ERR_CNT_EN
   logic       Err_clr;
   logic [1:0] Err_cnt;
   logic [1:0] err_exp;
`endif

   typedef struct packed {
      logic [7:0] y;
      logic       eq;
      logic [3:0] cnt;
   } res_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      res_t       exp;
   } vec_t;

   res_t        exp_q[$];
   res_t        pending;
   int          tests = 0;
   int          fails = 0;
   int          consumed = 0;
   bit          last_accept;
   bit          stall_prev = 0;
   logic [13:0] held;

   xnor_cmp_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .ERR_W(ERR_W)) dut (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .A         (A),
      .B         (B),
      .Valid_in  (Valid_in),
      .Ready_in  (Ready_in),
      .Y         (Y),
      .Eq        (Eq),
      .Match_cnt (Match_cnt),
      .Valid_out (Valid_out),
`ifdef XNOR_CMP_ERR_CNT_EN
      .Err_clr   (Err_clr),
      .Err_cnt   (Err_cnt),
`endif
      .Ready_out (Ready_out)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
      res_t r;
      r.y   = ~(a ^ b);
      r.cnt = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (r.y[i]) r.cnt = r.cnt + 4'd1;
      end
      r.eq = (a == b);
      return r;
   endfunction

   task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Inputs are set at the negedge; evaluation happens 3 ns later, 2 ns before
   // the rising edge, so every sampled value is settled.
   task automatic step();
      res_t e;
      bit   cons;
      last_accept = 0;
      cons = 0;
      #3;
      if (RSTn) begin
`ifdef XNOR_CMP_ERR_CNT_EN
         chk("err_cnt_track", Err_cnt === err_exp, Err_cnt, err_exp);
`endif
         if (stall_prev)
            chk("stall_hold", {Valid_out, Y, Eq, Match_cnt} === held, {Valid_out, Y, Eq, Match_cnt}, held);
         if (Valid_out && !Ready_out)
            chk("ready_in_stall", Ready_in === 1'b0, Ready_in, 0);
         else
            chk("ready_in_free", Ready_in === 1'b1, Ready_in, 1);
         if (Valid_in && Ready_in) begin
            exp_q.push_back(pending);
            last_accept = 1;
         end
         if (Valid_out && Ready_out) begin
            consumed++;
            if (exp_q.size() == 0) begin
               chk("unexpected_out", 1'b0, {Y, Eq, Match_cnt}, 0);
            end else begin
               e = exp_q.pop_front();
               cons = 1;
               chk("result", {Y, Eq, Match_cnt} === e, {Y, Eq, Match_cnt}, e);
            end
         end
`ifdef XNOR_CMP_ERR_CNT_EN
         if (Err_clr) err_exp = 2'd0;
         else if (cons && !e.eq && err_exp != 2'd3) err_exp = err_exp + 2'd1;
`endif
         stall_prev = Valid_out && !Ready_out;
         held = {Valid_out, Y, Eq, Match_cnt};
      end
      @(negedge CLK);
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input res_t exp);
      int n;
      A = a;
      B = b;
      Valid_in = 1'b1;
      pending = exp;
      n = 0;
      do begin
         step();
         n++;
      end while (!last_accept && n < 50);
      if (!last_accept) chk("send_timeout", 1'b0, n, 50);
      Valid_in = 1'b0;
   endtask

   task automatic drain();
      int n;
      Ready_out = 1'b1;
      Valid_in = 1'b0;
      n = 0;
      while (exp_q.size() > 0 && n < 50) begin
         step();
         n++;
      end
      chk("drain", exp_q.size() == 0, exp_q.size(), 0);
   endtask

   initial begin
      vec_t       vecs[6];
      logic [7:0] bp_a[4];
      int         n, idx, c0, stalls;

      vecs[0] = '{8'hA5, 8'hA5, '{8'hFF, 1'b1, 4'd8}};
      vecs[1] = '{8'h0F, 8'h00, '{8'hF0, 1'b0, 4'd4}};
      vecs[2] = '{8'hF0, 8'h0F, '{8'h00, 1'b0, 4'd0}};
      vecs[3] = '{8'h3C, 8'h3D, '{8'hFE, 1'b0, 4'd7}};
      vecs[4] = '{8'h55, 8'hAA, '{8'h00, 1'b0, 4'd0}};
      vecs[5] = '{8'h81, 8'h01, '{8'h7F, 1'b0, 4'd7}};
      bp_a[0] = 8'h00; bp_a[1] = 8'h01; bp_a[2] = 8'h03; bp_a[3] = 8'h07;

      RSTn = 1'b0;
      A = 8'h00;
      B = 8'h00;
      Valid_in = 1'b0;
      Ready_out = 1'b0;
`ifdef XNOR_CMP_ERR_CNT_EN
      Err_clr = 1'b0;
      err_exp = 2'd0;
`endif
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_valid_out", Valid_out === 1'b0, Valid_out, 0);
      chk("rst_y", Y === 8'h00, Y, 0);
      chk("rst_eq", Eq === 1'b0, Eq, 0);
      chk("rst_match_cnt", Match_cnt === 4'd0, Match_cnt, 0);
      chk("rst_ready_in", Ready_in === 1'b1, Ready_in, 1);
`ifdef XNOR_CMP_ERR_CNT_EN
      chk("rst_err_cnt", Err_cnt === 2'd0, Err_cnt, 0);
`endif
      @(negedge CLK);
      RSTn = 1'b1;
      step();
      chk("post_rst_valid_out", Valid_out === 1'b0, Valid_out, 0);

      // Latency: edges from accept edge up to Valid_out=1 must equal STAGES
      Ready_out = 1'b1;
      send(8'hA5, 8'hA5, model(8'hA5, 8'hA5));
      n = 1;
      while (!Valid_out && n < 10) begin
         step();
         n++;
      end
      chk("latency", n == STAGES, n, STAGES);
      chk("latency_y", Y === 8'hFF, Y, 8'hFF);
      drain();

      for (int i = 0; i < 6; i++) begin
         send(vecs[i].a, vecs[i].b, vecs[i].exp);
      end
      drain();

      // Backpressure: four back-to-back inputs, Ready_out low for cycles 2..6
      c0 = consumed;
      idx = 0;
      stalls = 0;
      for (int cyc = 0; cyc < 30 && (consumed - c0) < 4; cyc++) begin
         Ready_out = !(cyc >= 2 && cyc < 7);
         if (idx < 4) begin
            A = bp_a[idx];
            B = 8'h00;
            Valid_in = 1'b1;
            pending = model(A, B);
         end else begin
            Valid_in = 1'b0;
         end
         if (Valid_out && !Ready_out) stalls++;
         step();
         if (last_accept) idx++;
      end
      Valid_in = 1'b0;
      chk("bp_consumed", (consumed - c0) == 4, consumed - c0, 4);
      chk("bp_stalled", stalls >= 4, stalls, 4);
      drain();

      // Reset mid-flight
      Ready_out = 1'b1;
      send(8'h12, 8'h12, model(8'h12, 8'h12));
      send(8'h34, 8'h30, model(8'h34, 8'h30));
      Ready_out = 1'b0;
      #2;
      RSTn = 1'b0;
      #1;
      chk("midrst_valid_out", Valid_out === 1'b0, Valid_out, 0);
      chk("midrst_y", Y === 8'h00, Y, 0);
      chk("midrst_match_cnt", Match_cnt === 4'd0, Match_cnt, 0);
      chk("midrst_ready_in", Ready_in === 1'b1, Ready_in, 1);
      exp_q.delete();
      stall_prev = 0;
`ifdef XNOR_CMP_ERR_CNT_EN
      err_exp = 2'd0;
`endif
      @(negedge CLK);
      RSTn = 1'b1;
      Ready_out = 1'b1;
      c0 = consumed;
      repeat (6) step();
      chk("no_out_after_rst", consumed == c0, consumed - c0, 0);

      // Random traffic with random backpressure
      for (int i = 0; i < 80; i++) begin
         A = 8'($urandom);
         B = ($urandom_range(0, 3) == 0) ? A : 8'($urandom);
         Valid_in = 1'($urandom_range(0, 1));
         Ready_out = ($urandom_range(0, 3) != 0);
         pending = model(A, B);
         step();
      end
      drain();

`ifdef XNOR_CMP_ERR_CNT_EN
      Err_clr = 1'b1;
      step();
      Err_clr = 1'b0;
      Ready_out = 1'b1;
      for (int i = 0; i < 5; i++) send(8'h0F, 8'h00, model(8'h0F, 8'h00));
      drain();
      chk("err_saturated", Err_cnt === 2'd3, Err_cnt, 3);
      Ready_out = 1'b0;
      send(8'hF0, 8'h0F, model(8'hF0, 8'h0F));
      n = 0;
      while (!Valid_out && n < 10) begin
         step();
         n++;
      end
      chk("err_wait_valid", Valid_out === 1'b1, Valid_out, 1);
      Err_clr = 1'b1;
      Ready_out = 1'b1;
      step();
      Err_clr = 1'b0;
      chk("err_clr_priority", Err_cnt === 2'd0, Err_cnt, 0);
      drain();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/xnor_cmp_pipe.md
Name: xnor_cmp_pipe

Overview:
- Parametrised, pipelined successor to the 2-input XNOR gate.
- Computes bitwise XNOR of two WIDTH-bit operands, an all-equal flag and a count of matching bit positions.
- Uses a valid/ready handshake on both sides.
- Serves as the std_module comparator primitive for equality and match-scoring paths that need registered, back-pressured results.

Parameters:
- WIDTH, 8: operand width in bits, 1..64.
- STAGES, 2: pipeline depth in clock cycles from input accept to Valid_out, 1..4.
- ERR_W, 8: width of the mismatch counter (optional feature only).

Ports:
- CLK  in  1  single clock, rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- A  in  WIDTH  operand 0.
- B  in  WIDTH  operand 1.
- Valid_in  in  1  A/B valid.
- Ready_in  out  1  block can accept A/B this cycle.
- Y  out  WIDTH  bitwise ~(A^B).
- Eq  out  1  1 when all bits of Y are 1 (A==B).
- Match_cnt  out  CNT_W  number of 1s in Y; CNT_W = $clog2(WIDTH+1).
- Valid_out  out  1  Y/Eq/Match_cnt valid.
- Ready_out  in  1  downstream accepts the result.

Behaviour:
- Reset: one clock (CLK), async active-low reset (RSTn); reset polarity and synchronicity are fixed.
  - While RSTn=0, all stage valid bits, Valid_out, Y, Eq and Match_cnt are 0, and Ready_in is 1.
  - Reset takes effect immediately, not at the next edge.
  - Reset mid-operation discards all in-flight data; nothing emerges after release.
- Advance: advance = !Valid_out || Ready_out.
  - Ready_in = advance, combinational from Ready_out and the output valid register.
  - All stages shift together when advance=1.
  - When advance=0, every stage holds data and valid.
- Transfers: input accepted when Valid_in && Ready_in; output consumed when Valid_out && Ready_out.
- Latency: exactly STAGES cycles from accept edge to Valid_out=1 with no stall. Throughput 1 per cycle with Ready_out held high.
- Bubbles: an accepted cycle with Valid_in=0 inserts a bubble. Bubbles are not collapsed while stalled.
- Output stability: outputs are registered. While Valid_out=1 && Ready_out=0, Y/Eq/Match_cnt/Valid_out stay stable.
- Stage 1 registers Y and its valid bit.
  - The popcount adder tree is split across the remaining stages at implementer's choice.
  - STAGES=1 computes everything combinationally before a single register.
- Match_cnt: unsigned, no overflow possible (max WIDTH).
- Eq: equals (Match_cnt == WIDTH).
- Simultaneous accept and consume in the same cycle is legal and loses nothing.
- Order is strictly preserved.
- No X on outputs after reset for any legal input sequence.

Optional Feature:
- Macro: XNOR_CMP_ERR_CNT_EN.
- Defined:
  - Adds input Err_clr (1) and output Err_cnt (ERR_W).
  - Err_cnt increments on each consumed output with Eq=0, saturating at 2^ERR_W-1.
  - Err_clr=1 forces Err_cnt to 0 at the next edge and has priority over a same-cycle increment.
  - Reset value 0.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Package xnor_cmp_pkg holds:
  - function cnt_w(width) returning $clog2(width+1);
  - MAX_STAGES=4 constant;
  - parameter range-check localparams.
- Sub-module xnor_cmp_stage:
  - one pipeline slice with a data/valid register, enable = advance, async active-low reset;
  - instantiated STAGES times by a generate loop.

Test Plan (WIDTH=8, STAGES=2 unless noted):
- Reset: RSTn=0 then released → Valid_out=0, Y=8'h00, Eq=0, Match_cnt=0, Ready_in=1.
- Equal operands: A=8'hA5, B=8'hA5, Ready_out=1 → after 2 cycles Y=8'hFF, Eq=1, Match_cnt=8.
- Mismatch: A=8'h0F, B=8'h00 → Y=8'hF0, Eq=0, Match_cnt=4.
- Full mismatch: A=8'hF0, B=8'h0F → Y=8'h00, Eq=0, Match_cnt=0.
- Backpressure:
  - stimulus: 4 back-to-back inputs (00/00, 01/00, 03/00, 07/00) with Ready_out=0 from cycle 2 for 5 cycles;
  - required: Ready_in drops when Valid_out is held, outputs stay stable, then Match_cnt sequence 8,7,6,5 with no loss or duplication.
- Reset mid-flight: 2 transactions in flight, RSTn pulsed low between edges → Valid_out=0 immediately, no result after release.
- Mismatch counter (XNOR_CMP_ERR_CNT_EN, ERR_W=2):
  - 5 consumed mismatches → Err_cnt=3 (saturated);
  - Err_clr=1 concurrent with a mismatch → Err_cnt=0.
